// File: rtl/grid_renderer_pkg.sv
// grid_renderer_pkg: grid dimensions, cell-value encodings and colour constants
// shared by the renderer and the level loading logic.
package grid_renderer_pkg;
  localparam int GRID_W = 40;
  localparam int GRID_H = 30;
  typedef enum logic [2:0] {
    CELL_EMPTY = 3'd0,
    CELL_WALL  = 3'd1,
    CELL_FIRE  = 3'd2,
    CELL_GRASS = 3'd3,
    CELL_WATER = 3'd4,
    CELL_GOLD  = 3'd5
  } cell_t;
  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_WHITE  = 3'b111;
  localparam logic [2:0] COL_RED    = 3'b100;
  localparam logic [2:0] COL_GREEN  = 3'b010;
  localparam logic [2:0] COL_BLUE   = 3'b001;
  localparam logic [2:0] COL_YELLOW = 3'b110;
endpackage

// File: rtl/grid_colour_lut.sv
// grid_colour_lut: maps a 3-bit cell value to its RGB plot colour.
module grid_colour_lut
  import grid_renderer_pkg::*;
(
  input  logic [2:0] value,
  output logic [2:0] colour
);
  // Values 5..7 all render as gold.
  always_comb colour = value == CELL_EMPTY ? COL_BLACK :
                       value == CELL_WALL  ? COL_WHITE :
                       value == CELL_FIRE  ? COL_RED   :
                       value == CELL_GRASS ? COL_GREEN :
                       value == CELL_WATER ? COL_BLUE  : COL_YELLOW;
endmodule

// File: rtl/grid_renderer.sv
// grid_renderer: walks the grid row-major and plots each cell as a 4x4 pixel block.
module grid_renderer #(
  parameter int GRID_W  = grid_renderer_pkg::GRID_W,
  parameter int GRID_H  = grid_renderer_pkg::GRID_H,
  parameter int CELL_PX = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic [5:0] grid_x,
  output logic [4:0] grid_y,
  input  logic [2:0] grid_out,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);
  import grid_renderer_pkg::*;
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] INIT    = 3'd1;
  localparam logic [2:0] FETCH   = 3'd2;
  localparam logic [2:0] LATCH   = 3'd3;
  localparam logic [2:0] PLOT    = 3'd4;
  localparam logic [2:0] ADVANCE = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;
  localparam logic [5:0] X_LAST   = 6'(GRID_W - 1);
  localparam logic [4:0] Y_LAST   = 5'(GRID_H - 1);
  localparam logic [3:0] CNT_LAST = 4'(CELL_PX * CELL_PX - 1);
  logic [2:0] state;
  logic [3:0] cnt;
  logic [2:0] colour;
  grid_colour_lut u_lut (.value(grid_out), .colour(colour));
  assign vga_plot = state == PLOT;
  assign done     = state == DONE;
  // With 4-pixel cells, concatenation is the exact x*4+offset with no truncation.
  assign vga_x = {grid_x, cnt[1:0]};
  assign vga_y = {grid_y, cnt[3:2]};
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      grid_x     <= '0;
      grid_y     <= '0;
      cnt        <= '0;
      vga_colour <= '0;
    end else begin
      case (state)
        IDLE: state <= start ? INIT : IDLE;
        INIT: begin
          grid_x <= '0;
          grid_y <= '0;
          cnt    <= '0;
          state  <= FETCH;
        end
        FETCH: state <= LATCH;
        LATCH: begin
          vga_colour <= colour;
          state      <= PLOT;
        end
        PLOT: begin
          cnt   <= cnt + 4'd1;
          state <= cnt == CNT_LAST ? ADVANCE : PLOT;
        end
        ADVANCE: begin
          if (grid_x == X_LAST && grid_y == Y_LAST) begin
            state <= DONE;
          end else begin
            grid_x <= grid_x == X_LAST ? 6'd0 : grid_x + 6'd1;
            grid_y <= grid_x == X_LAST ? grid_y + 5'd1 : grid_y;
            state  <= FETCH;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_grid_renderer.sv
// tb_grid_renderer: scoreboard bench; stimulus queues expected plots/done, a monitor checks them.
module tb_grid_renderer;
  logic       clock = 0;
  logic       reset = 0;
  logic       start = 0;
  logic       done;
  logic [5:0] grid_x;
  logic [4:0] grid_y;
  logic [2:0] grid_out = 0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  grid_renderer dut (
    .clock(clock), .reset(reset), .start(start), .done(done),
    .grid_x(grid_x), .grid_y(grid_y), .grid_out(grid_out),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );
  always #5 clock = ~clock;
  typedef struct {int x; int y; logic [2:0] col; int cyc;} exp_t;
  exp_t exp_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   chk = 0;
  logic [2:0] mem [30][40];
  logic [2:0] cmap [8];
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) grid_out <= (grid_y < 30 && grid_x < 40) ? mem[grid_y][grid_x] : 3'd0;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic push_cells(input int s, input int ncells, input int last_pix);
    for (int k = 0; k <= ncells; k++) begin
      int np;
      np = (k < ncells) ? 16 : last_pix + 1;
      for (int p = 0; p < np; p++) begin
        exp_t e;
        e.x   = (k % 40) * 4 + p % 4;
        e.y   = (k / 40) * 4 + p / 4;
        e.col = cmap[mem[k / 40][k % 40]];
        e.cyc = (k == 0 && p == 0) ? s + 4 : -1;
        exp_q.push_back(e);
      end
    end
  endtask
  always @(negedge clock) begin
    if (vga_plot && done) begin
      fails++;
      $display("FAIL plot_done_overlap at cycle %0d", cyc);
    end
    if (vga_plot) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_plot cycle %0d got (%0d,%0d) col %b, none expected", cyc, vga_x, vga_y, vga_colour);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (int'(vga_x) != e.x || int'(vga_y) != e.y || vga_colour !== e.col) begin
          fails++;
          $display("FAIL plot_pixel cycle %0d got (%0d,%0d) col %b, want (%0d,%0d) col %b", cyc, vga_x, vga_y, vga_colour, e.x, e.y, e.col);
        end
        if (e.cyc >= 0) begin
          tests++;
          if (cyc != e.cyc) begin
            fails++;
            $display("FAIL first_plot_cycle got %0d want %0d", cyc, e.cyc);
          end
        end
      end
      tests++;
      if (vga_x > 8'd159 || vga_y > 7'd119) begin
        fails++;
        $display("FAIL pixel_range got (%0d,%0d) max (159,119)", vga_x, vga_y);
      end
    end
    if (done) begin
      tests++;
      if (done_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        int d;
        d = done_q.pop_front();
        if (cyc != d) begin
          fails++;
          $display("FAIL done_cycle got %0d want %0d", cyc, d);
        end
      end
    end
    if (chk == 1) begin
      tests++;
      if (vga_plot !== 1'b0 || done !== 1'b0 || vga_x !== 8'd0 || vga_y !== 7'd0 ||
          vga_colour !== 3'd0 || grid_x !== 6'd0 || grid_y !== 5'd0) begin
        fails++;
        $display("FAIL reset_outputs got plot=%b done=%b x=%0d y=%0d col=%b gx=%0d gy=%0d, want all 0",
                 vga_plot, done, vga_x, vga_y, vga_colour, grid_x, grid_y);
      end
    end
    if (chk == 2) begin
      tests++;
      if (exp_q.size() != 0 || done_q.size() != 0) begin
        fails++;
        $display("FAIL pending_expectations got %0d plots and %0d dones outstanding, want 0", exp_q.size(), done_q.size());
      end
    end
  end
  initial begin
    int c;
    cmap[0] = 3'b000; cmap[1] = 3'b111; cmap[2] = 3'b100; cmap[3] = 3'b010;
    cmap[4] = 3'b001; cmap[5] = 3'b110; cmap[6] = 3'b110; cmap[7] = 3'b110;
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 40; x++)
        mem[y][x] = 3'd0;
    mem[0][0] = 3'd2;
    mem[0][1] = 3'd1;
    mem[0][2] = 3'd3;
    mem[0][3] = 3'd4;
    mem[0][4] = 3'd5;
    mem[0][5] = 3'd6;
    mem[29][39] = 3'd7;
    // reset low for two edges, then idle with no plots
    tick();
    tick();
    reset = 1;
    chk = 1;
    tick();
    chk = 0;
    repeat (10) tick();
    chk = 2;
    tick();
    chk = 0;
    // single full render
    c = cyc;
    push_cells(c, 1200, -1);
    done_q.push_back(c + 22802);
    start = 1;
    tick();
    start = 0;
    repeat (22805) tick();
    chk = 2;
    tick();
    chk = 0;
    // stray start mid-render, then reset during PLOT of cell (10,5) pixel 5
    c = cyc;
    push_cells(c, 5 * 40 + 10, 5);
    start = 1;
    tick();
    start = 0;
    repeat (999) tick();
    start = 1;
    tick();
    start = 0;
    repeat (3999 - 1001) tick();
    reset = 0;
    tick();
    reset = 1;
    chk = 1;
    tick();
    chk = 0;
    repeat (40) tick();
    chk = 2;
    tick();
    chk = 0;
    // start held high: back-to-back renders with one IDLE cycle between
    c = cyc;
    push_cells(c, 1200, -1);
    done_q.push_back(c + 22802);
    push_cells(c + 22803, 1200, -1);
    done_q.push_back(c + 22803 + 22802);
    start = 1;
    repeat (22804) tick();
    start = 0;
    repeat (22805) tick();
    chk = 2;
    tick();
    chk = 0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/grid_renderer.md
GRID_RENDERER -- requirements
Module: grid_renderer

Interface
REQ-001 Parameter GRID_W, default 40: cells per grid row.
REQ-002 Parameter GRID_H, default 30: cell rows per grid.
REQ-003 Parameter CELL_PX, default 4: pixel edge length of one rendered cell; only 4 is supported.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset; 0 sampled at a rising edge resets the block.
REQ-006 start  in  1  request to render the whole grid; sampled only in IDLE.
REQ-007 done  out  1  one-cycle pulse when the full grid has been plotted.
REQ-008 grid_x  out  6  grid read column address, 0..39.
REQ-009 grid_y  out  5  grid read row address, 0..29.
REQ-010 grid_out  in  3  grid cell value; valid one cycle after grid_x/grid_y are held stable.
REQ-011 vga_x  out  8  pixel column, 0..159.
REQ-012 vga_y  out  7  pixel row, 0..119.
REQ-013 vga_colour  out  3  pixel colour, RGB bit order.
REQ-014 vga_plot  out  1  write strobe; the adapter writes one pixel per cycle while high.

Function
REQ-015 The FSM SHALL have the states IDLE, INIT, FETCH, LATCH, PLOT, ADVANCE and DONE.
REQ-016 IDLE SHALL go to INIT when start=1 and SHALL otherwise stay in IDLE.
REQ-017 INIT SHALL clear grid_x, grid_y and the 4-bit pixel counter, then go to FETCH.
REQ-018 FETCH SHALL hold the address for one cycle, then go to LATCH.
REQ-019 LATCH SHALL register the colour lookup of grid_out into vga_colour, then go to PLOT.
REQ-020 PLOT SHALL assert vga_plot for exactly 16 consecutive cycles, with the pixel counter running from 0 to 15, then go to ADVANCE.
REQ-021 During PLOT: vga_x = grid_x*4 + cnt[1:0] and vga_y = grid_y*4 + cnt[3:2], so the scan is row-major within the cell.
REQ-022 vga_x and vga_y SHALL be computed at full width, with no truncation; the largest values are 159 and 119.
REQ-023 ADVANCE SHALL go to DONE if grid_x=39 and grid_y=29.
REQ-024 Otherwise, ADVANCE SHALL increment grid_x, or if grid_x=39 set grid_x=0 and increment grid_y, then go to FETCH.
REQ-025 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-026 Each cell SHALL take exactly 19 cycles; a full render SHALL take 22801 cycles from INIT to the last ADVANCE.
REQ-027 The colour map SHALL be: 0->000, 1->111, 2->100, 3->010, 4->001, 5/6/7->110.
REQ-028 start SHALL be ignored in every state except IDLE.
REQ-029 If start is held high through DONE, the block SHALL spend one cycle in IDLE and then restart.
REQ-030 vga_plot and done SHALL never be high in the same cycle.
REQ-031 vga_plot SHALL be 0 in every state other than PLOT.

Reset
REQ-032 On reset=0, the state SHALL become IDLE and done, vga_plot, grid_x, grid_y, vga_x, vga_y, vga_colour and the pixel counter SHALL all be 0.
REQ-033 A reset during any state SHALL take effect at that edge, with no further vga_plot or done until a new start.
REQ-034 Reset SHALL take priority over start.

Structure
REQ-035 GRID_W, GRID_H, the cell-value encodings and the 3-bit colour constants SHALL live in the shared package, which the level loading logic also uses.
REQ-036 The colour mapping SHALL be a combinational sub-module named grid_colour_lut (3-bit value in, 3-bit colour out).
REQ-037 The FSM and the counters/datapath SHALL stay in grid_renderer.

Verification
REQ-038 Reset check: assert reset=0 for 2 cycles, release -> all outputs 0, state IDLE, and no vga_plot for 10 idle cycles.
REQ-039 All-zero grid, one start pulse -> exactly 19200 vga_plot cycles with colour 000; done pulses exactly once, 22802 cycles after the start edge.
REQ-040 Cell (0,0)=2, all others 0 -> the first 16 plots are colour 100 at pixels (0..3, 0..3) in row-major order; the first plot appears 4 cycles after the start edge.
REQ-041 Cell (39,29)=7 -> the last 16 plots are colour 110 at pixels (156..159, 116..119); vga_x never exceeds 159 and vga_y never exceeds 119.
REQ-042 start pulsed again mid-render -> no restart, and the plot count is unchanged; then reset=0 during PLOT of cell (10,5) -> vga_plot drops at that edge and there is no done.
REQ-043 start held high continuously -> done, then one IDLE cycle, then INIT; the second render is identical to the first.
